host_frame_loader: RTL
======================

// Module: host_frame_loader
// PURPOSE
//  Upstream loader between the host UART and the EPROM image buffer. Parses framed host
//  uploads from the UART RX byte stream and writes payload bytes into the 2 KB buffer.
//  Checks the frame checksum and returns a one-byte ACK/NAK to the host through the UART
//  TX handshake. Pulses load_done so the programmer FSM may start burning the 8755.
// PARAMETERS
//  ADDR_W          11          buffer address width (2048-byte 8755 array)
//  SYNC_BYTE       8'hA5       frame start marker
//  ACK_BYTE        8'h06       response on good frame
//  NAK_BYTE        8'h15       response on bad length/checksum/timeout
//  TIMEOUT_CYCLES  5_000_000   max idle clocks between bytes inside a frame (100 ms @ 50 MHz)
// PORTS
//  clk          in   1        system clock
//  rst_n        in   1        synchronous reset, active low
//  rx_data      in   8        UART received byte
//  rx_valid     in   1        1-cycle strobe, rx_data valid
//  lock         in   1        high while programmer is burning; new frames refused
//  tx_busy      in   1        UART transmitter busy
//  tx_data      out  8        response byte to UART
//  new_tx_data  out  1        1-cycle strobe, tx_data valid
//  wr_en        out  1        buffer write strobe
//  wr_addr      out  ADDR_W   buffer write address
//  wr_data      out  8        buffer write data
//  byte_count   out  ADDR_W+1 payload bytes written in current/last frame
//  load_done    out  1        1-cycle pulse, frame accepted (same cycle as ACK strobe)
//  load_err     out  1        1-cycle pulse, frame rejected (same cycle as NAK strobe)
// BEHAVIOUR
//  Frame: SYNC, LEN_H, LEN_L, LEN payload bytes, CSUM. LEN = {LEN_H[2:0],LEN_L}, 1..2048;
//   LEN=0 encodes 2048. LEN_H[7:3] != 0 -> error.
//  CSUM valid iff (sum of payload bytes + CSUM) mod 256 == 0.
//  Reset (rst_n low at a clk edge): state IDLE; all outputs 0; counters and sum cleared.
//   Applies mid-frame too: the partial frame is abandoned, no response sent.
//  FSM:
//   IDLE  : rx_valid & rx_data==SYNC & !lock -> LEN_H; any other byte dropped.
//   LEN_H : on rx_valid latch; bits[7:3]!=0 -> RESP(NAK) else -> LEN_L.
//   LEN_L : on rx_valid latch -> DATA; count=0, sum=0.
//   DATA  : on rx_valid -> next cycle wr_en=1, wr_addr=count, wr_data=byte (1-cycle latency);
//           count++, sum+=byte; after LEN-th byte -> CSUM. Addresses run 0..LEN-1, no wrap.
//   CSUM  : on rx_valid -> RESP with ACK if checksum good, else NAK.
//   RESP  : wait while tx_busy; first cycle tx_busy==0 -> new_tx_data=1 for one cycle,
//           tx_data=ACK/NAK, load_done or load_err in the same cycle -> IDLE.
//  Timeout: counter cleared on every rx_valid and on entering LEN_H. In LEN_H/LEN_L/DATA/CSUM,
//   reaching TIMEOUT_CYCLES -> RESP(NAK). rx_valid in the same cycle as expiry: byte wins.
//  Bytes arriving during RESP are dropped. lock is sampled only in IDLE; an in-progress
//   frame completes normally even if lock rises.
//  byte_count holds the final count until the next SYNC is accepted, then clears.
//  wr_en never asserts outside DATA-byte cycles; buffer contents beyond LEN are untouched.
// TESTING
//  A5 00 04 11 22 33 44 56 -> wr_en x4, addr 0..3 data 11,22,33,44; tx 06; load_done; count=4.
//  A5 00 02 10 20 00 -> two writes, tx 15 (bad csum), load_err=1, load_done=0.
//  A5 08 ... -> tx 15 immediately after LEN_H, no wr_en; next good frame accepted.
//  A5 00 00 + 2048 bytes (all 01) + 00 -> addr 0..2047 written, tx 06, count=2048.
//  A5 00 03 AA then silence TIMEOUT_CYCLES -> one write, tx 15; lock=1 then A5 -> ignored.
//  tx_busy held high 100 cycles at frame end -> new_tx_data waits, fires once when released;
//   rst_n low mid-DATA -> all outputs 0, no response, IDLE.

Source files
------------

// File: rtl/host_frame_loader.sv
// Host upload frame parser: SYNC, LEN_H, LEN_L, payload, CSUM -> buffer writes.
// Answers each parsed frame with one ACK/NAK byte over the UART TX handshake.
module host_frame_loader #(
    parameter int         ADDR_W         = 11,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter logic [7:0] ACK_BYTE       = 8'h06,
    parameter logic [7:0] NAK_BYTE       = 8'h15,
    parameter int         TIMEOUT_CYCLES = 5_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              lock,
    input  logic              tx_busy,
    output logic [7:0]        tx_data,
    output logic              new_tx_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [ADDR_W:0]   byte_count,
    output logic              load_done,
    output logic              load_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TMR_ONE = TW'(1);
    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0] FULL_LEN = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_H,
        S_LEN_L,
        S_DATA,
        S_CSUM,
        S_RESP
    } state_t;

    state_t state, state_next;

    logic [2:0]        len_h;
    logic [ADDR_W:0]   len;
    logic [ADDR_W:0]   cnt;
    logic [7:0]        sum;
    logic [TW-1:0]     tmr;
    logic              ack;

    logic              expired;
    logic              last_byte;
    logic [ADDR_W:0]   cnt_next;
    logic [7:0]        sum_next;
    logic [ADDR_W-1:0] len_raw;
    logic              fire;

    assign cnt_next   = cnt + CNT_ONE;
    assign sum_next   = sum + rx_data;
    assign len_raw    = ADDR_W'({len_h, rx_data});
    assign last_byte  = (cnt_next == len);
    assign expired    = (tmr == TMR_LAST);
    assign byte_count = cnt;

    always_comb begin
        state_next  = state;
        fire        = 1'b0;
        new_tx_data = 1'b0;
        tx_data     = 8'h00;
        load_done   = 1'b0;
        load_err    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (rx_valid && rx_data == SYNC_BYTE && !lock)
                    state_next = S_LEN_H;
            end
            S_LEN_H: begin
                if (rx_valid)
                    state_next = (|rx_data[7:3]) ? S_RESP : S_LEN_L;
                else if (expired)
                    state_next = S_RESP;
            end
            S_LEN_L: begin
                if (rx_valid)
                    state_next = S_DATA;
                else if (expired)
                    state_next = S_RESP;
            end
            S_DATA: begin
                if (rx_valid) begin
                    if (last_byte)
                        state_next = S_CSUM;
                end else if (expired) begin
                    state_next = S_RESP;
                end
            end
            S_CSUM: begin
                if (rx_valid || expired)
                    state_next = S_RESP;
            end
            S_RESP: begin
                if (!tx_busy) begin
                    fire       = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
        // response strobe and its status pulse share one cycle
        if (fire) begin
            new_tx_data = 1'b1;
            tx_data     = ack ? ACK_BYTE : NAK_BYTE;
            load_done   = ack;
            load_err    = !ack;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            len_h   <= '0;
            len     <= '0;
            cnt     <= '0;
            sum     <= '0;
            tmr     <= '0;
            ack     <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            state <= state_next;
            wr_en <= 1'b0;
            // idle gap timer only runs while a frame is open
            if (state == S_IDLE || state == S_RESP)
                tmr <= '0;
            else
                tmr <= rx_valid ? '0 : tmr + TMR_ONE;
            unique case (state)
                S_IDLE: begin
                    if (state_next == S_LEN_H) begin
                        cnt <= '0;
                        sum <= '0;
                        ack <= 1'b0;
                    end
                end
                S_LEN_H: begin
                    if (rx_valid)
                        len_h <= rx_data[2:0];
                end
                S_LEN_L: begin
                    if (rx_valid) begin
                        len <= (len_raw == '0) ? FULL_LEN
                                               : {1'b0, len_raw};
                        cnt <= '0;
                        sum <= '0;
                    end
                end
                S_DATA: begin
                    if (rx_valid) begin
                        wr_en   <= 1'b1;
                        wr_addr <= cnt[ADDR_W-1:0];
                        wr_data <= rx_data;
                        cnt     <= cnt_next;
                        sum     <= sum_next;
                    end
                end
                S_CSUM: begin
                    if (rx_valid)
                        ack <= (sum_next == 8'h00);
                end
                default: ;
            endcase
        end
    end

endmodule
